// File: rtl/clut_cache_pkg.sv
// GPU-shared constants and types used by the CLUT cache slice.
package clut_cache_pkg;

    typedef enum logic [1:0] {PIX_4BIT, PIX_8BIT, PIX_16BIT} pixFmt_e;

    typedef enum logic [1:0] {ClutIdle, ClutReq, ClutData} clutState_e;

    localparam int unsigned VRAM_ADDR_W = 18;
    localparam int unsigned BURST_BEATS = 8;
    localparam int unsigned BeatW       = $clog2(BURST_BEATS);
    // 256 entries at 16 entries per burst.
    localparam int unsigned CLUT_BURSTS = 16;
    localparam int unsigned BurstW      = $clog2(CLUT_BURSTS);

endpackage

// File: rtl/clut_cache_if.sv
// Load, VRAM burst and dual lookup signals between the GPU front end and the CLUT cache.
interface clut_cache_if;
    import clut_cache_pkg::*;

    logic                   i_loadReq;
    logic [5:0]             i_clutX;
    logic [8:0]             i_clutY;
    logic                   i_is8bit;
    logic                   o_busy;
    logic                   o_memReq;
    logic [VRAM_ADDR_W-1:0] o_memAddr;
    logic                   i_memAck;
    logic                   i_memDataValid;
    logic [31:0]            i_memData;
    logic                   i_lookupValidA;
    logic                   i_lookupValidB;
    logic [7:0]             i_indexA;
    logic [7:0]             i_indexB;
    logic [15:0]            o_clutValueA;
    logic [15:0]            o_clutValueB;

    modport slave (
        input  i_loadReq, i_clutX, i_clutY, i_is8bit, i_memAck, i_memDataValid, i_memData,
               i_lookupValidA, i_lookupValidB, i_indexA, i_indexB,
        output o_busy, o_memReq, o_memAddr, o_clutValueA, o_clutValueB
    );

    modport master (
        output i_loadReq, i_clutX, i_clutY, i_is8bit, i_memAck, i_memDataValid, i_memData,
               i_lookupValidA, i_lookupValidB, i_indexA, i_indexB,
        input  o_busy, o_memReq, o_memAddr, o_clutValueA, o_clutValueB
    );

endinterface

// File: rtl/clut_cache_ram_2r1w.sv
// 256x16 palette RAM: one 2-entry-wide write port, two registered read ports.
// Built as two 128x32 copies so each read port owns a bank.
module clut_cache_ram_2r1w (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn_i,
    input  logic [6:0]  wrAddr_i,
    input  logic [31:0] wrData_i,
    input  logic        rdEnA_i,
    input  logic [7:0]  rdIdxA_i,
    input  logic        rdEnB_i,
    input  logic [7:0]  rdIdxB_i,
    output logic [15:0] rdDataA_o,
    output logic [15:0] rdDataB_o
);

    logic [31:0] bankA [128];
    logic [31:0] bankB [128];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            bankA[wrAddr_i] <= wrData_i;
            bankB[wrAddr_i] <= wrData_i;
        end
    end

    // Reads sample the array before this edge's write lands, so a collision returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdDataA_o <= '0;
            rdDataB_o <= '0;
        end else begin
            if (rdEnA_i) begin
                rdDataA_o <= rdIdxA_i[0] ? bankA[rdIdxA_i[7:1]][31:16]
                                         : bankA[rdIdxA_i[7:1]][15:0];
            end
            if (rdEnB_i) begin
                rdDataB_o <= rdIdxB_i[0] ? bankB[rdIdxB_i[7:1]][31:16]
                                         : bankB[rdIdxB_i[7:1]][15:0];
            end
        end
    end

endmodule

// File: rtl/clut_cache.sv
// CLUT cache: palette RAM filled from VRAM bursts, answering two lookups per cycle.
// Define CLUT_CACHE_HIT_EN to skip refetches of the resident palette.
module clut_cache
    import clut_cache_pkg::*;
(
    input logic         clk,
    input logic         rst,
    clut_cache_if.slave bus
);

    clutState_e        stateQ, stateD;
    logic [BurstW-1:0] burstQ, burstD;
    logic [BeatW-1:0]  beatQ, beatD;
    logic [5:0]        xQ, xD;
    logic [8:0]        yQ, yD;
    pixFmt_e           fmtQ, fmtD;
    logic              hit;
    logic              ramWe;
    logic [8:0]        col;

`ifdef CLUT_CACHE_HIT_EN
    logic tagValidQ, tagValidD;

    // An 8-bit palette also covers a 4-bit request at the same position.
    assign hit = tagValidQ && (bus.i_clutX == xQ) && (bus.i_clutY == yQ) &&
                 ((fmtQ == PIX_8BIT) || !bus.i_is8bit);

    always_ff @(posedge clk) begin
        if (rst) tagValidQ <= 1'b0;
        else     tagValidQ <= tagValidD;
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        stateD = stateQ;
        burstD = burstQ;
        beatD  = beatQ;
        xD     = xQ;
        yD     = yQ;
        fmtD   = fmtQ;
        ramWe  = 1'b0;
`ifdef CLUT_CACHE_HIT_EN
        tagValidD = tagValidQ;
`endif
        unique case (stateQ)
            ClutIdle: begin
                if (bus.i_loadReq && !hit) begin
`ifdef CLUT_CACHE_HIT_EN
                    tagValidD = 1'b0;
`endif
                    burstD = '0;
                    xD     = bus.i_clutX;
                    yD     = bus.i_clutY;
                    fmtD   = bus.i_is8bit ? PIX_8BIT : PIX_4BIT;
                    stateD = ClutReq;
                end
            end
            ClutReq: begin
                if (bus.i_memAck) begin
                    beatD  = '0;
                    stateD = ClutData;
                end
            end
            ClutData: begin
                if (bus.i_memDataValid) begin
                    ramWe = 1'b1;
                    beatD = beatQ + 1'b1;
                    if (beatQ == BeatW'(BURST_BEATS - 1)) begin
                        if (fmtQ != PIX_8BIT || burstQ == BurstW'(CLUT_BURSTS - 1)) begin
`ifdef CLUT_CACHE_HIT_EN
                            tagValidD = 1'b1;
`endif
                            stateD = ClutIdle;
                        end else begin
                            burstD = burstQ + 1'b1;
                            stateD = ClutReq;
                        end
                    end
                end
            end
            default: stateD = ClutIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= ClutIdle;
            burstQ <= '0;
            beatQ  <= '0;
            xQ     <= '0;
            yQ     <= '0;
            fmtQ   <= PIX_4BIT;
        end else begin
            stateQ <= stateD;
            burstQ <= burstD;
            beatQ  <= beatD;
            xQ     <= xD;
            yQ     <= yD;
            fmtQ   <= fmtD;
        end
    end

    // Column wraps mod 512 so a fetch never leaves the VRAM line.
    assign col           = {xQ, 3'b000} + {2'b00, burstQ, 3'b000};
    assign bus.o_busy    = (stateQ != ClutIdle);
    assign bus.o_memReq  = (stateQ == ClutReq);
    assign bus.o_memAddr = (stateQ == ClutReq) ? {yQ, col} : '0;

    clut_cache_ram_2r1w u_ram (
        .clk       (clk),
        .rst       (rst),
        .wrEn_i    (ramWe),
        .wrAddr_i  ({burstQ, beatQ}),
        .wrData_i  (bus.i_memData),
        .rdEnA_i   (bus.i_lookupValidA),
        .rdIdxA_i  (bus.i_indexA),
        .rdEnB_i   (bus.i_lookupValidB),
        .rdIdxB_i  (bus.i_indexB),
        .rdDataA_o (bus.o_clutValueA),
        .rdDataB_o (bus.o_clutValueB)
    );

endmodule

// File: tb/tb_clut_cache.sv
// Directed bench for clut_cache: fills, lookups, address wrap, reset mid-fill, collisions.
module tb_clut_cache;
    import clut_cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    clut_cache_if bus();

    clut_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input int x, input int y, input bit is8);
        bus.i_clutX   = 6'(x);
        bus.i_clutY   = 9'(y);
        bus.i_is8bit  = is8;
        bus.i_loadReq = 1'b1;
        step();
        bus.i_loadReq = 1'b0;
    endtask

    task automatic waitReq(input string tag, input int x, input int y, input int b);
        int n = 0;
        logic [8:0] c;
        while (!bus.o_memReq && n < 50) begin
            step();
            n++;
        end
        c = 9'((x * 8 + b * 8) % 512);
        chk({tag, "_req"}, 32'(bus.o_memReq), 32'd1);
        chk({tag, "_addr"}, 32'(bus.o_memAddr), 32'({9'(y), c}));
    endtask

    // Arbiter grants three cycles after the request appears.
    task automatic grant();
        repeat (3) step();
        bus.i_memAck = 1'b1;
        step();
        bus.i_memAck = 1'b0;
    endtask

    task automatic beat(input int base, input int b, input int t);
        int e;
        e = base + 16 * b + 2 * t;
        bus.i_memDataValid = 1'b1;
        bus.i_memData      = {16'(e + 1), 16'(e)};
        step();
        bus.i_memDataValid = 1'b0;
    endtask

    task automatic fillBursts(input string tag, input int x, input int y, input int base,
                              input int first, input int count);
        for (int b = first; b < first + count; b++) begin
            waitReq(tag, x, y, b);
            grant();
            for (int t = 0; t < 8; t++) beat(base, b, t);
        end
    endtask

    task automatic lookup(input int ia, input int ib);
        bus.i_lookupValidA = 1'b1;
        bus.i_lookupValidB = 1'b1;
        bus.i_indexA       = 8'(ia);
        bus.i_indexB       = 8'(ib);
        step();
        bus.i_lookupValidA = 1'b0;
        bus.i_lookupValidB = 1'b0;
    endtask

    initial begin
        bus.i_loadReq      = 1'b0;
        bus.i_clutX        = '0;
        bus.i_clutY        = '0;
        bus.i_is8bit       = 1'b0;
        bus.i_memAck       = 1'b0;
        bus.i_memDataValid = 1'b0;
        bus.i_memData      = '0;
        bus.i_lookupValidA = 1'b0;
        bus.i_lookupValidB = 1'b0;
        bus.i_indexA       = '0;
        bus.i_indexB       = '0;

        // Reset state
        repeat (2) step();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_memReq", 32'(bus.o_memReq), 0);
        chk("rst_memAddr", 32'(bus.o_memAddr), 0);
        chk("rst_valA", 32'(bus.o_clutValueA), 0);
        chk("rst_valB", 32'(bus.o_clutValueB), 0);

        // 4-bit fill at X=2, Y=480: one burst at column 16
        load(2, 480, 1'b0);
        chk("l4_busy", 32'(bus.o_busy), 1);
        fillBursts("l4", 2, 480, 'h1000, 0, 1);
        chk("l4_done", 32'(bus.o_busy), 0);
        for (int k = 0; k < 16; k++) begin
            lookup(k, 15 - k);
            chk("l4_lkA", 32'(bus.o_clutValueA), 32'('h1000 + k));
            chk("l4_lkB", 32'(bus.o_clutValueB), 32'('h100F - k));
        end
        bus.i_indexA = 8'd3;
        step();
        chk("holdA", 32'(bus.o_clutValueA), 32'h100F);
        chk("holdB", 32'(bus.o_clutValueB), 32'h1000);

        // 8-bit fill at X=5, Y=10: columns 40..160
        load(5, 10, 1'b1);
        fillBursts("l8", 5, 10, 'h2000, 0, 16);
        chk("l8_done", 32'(bus.o_busy), 0);
        lookup('hFF, 'h80);
        chk("l8_lkFF", 32'(bus.o_clutValueA), 32'h20FF);
        chk("l8_lk80", 32'(bus.o_clutValueB), 32'h2080);

        // Repeat load, then 4-bit at the same position
`ifdef CLUT_CACHE_HIT_EN
        load(5, 10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("hit8_busy", 32'(bus.o_busy), 0);
            chk("hit8_req", 32'(bus.o_memReq), 0);
            step();
        end
        load(5, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("hit4_busy", 32'(bus.o_busy), 0);
            chk("hit4_req", 32'(bus.o_memReq), 0);
            step();
        end
`else
        load(5, 10, 1'b1);
        chk("re8_busy", 32'(bus.o_busy), 1);
        fillBursts("re8", 5, 10, 'h2000, 0, 16);
        load(5, 10, 1'b0);
        chk("re4_busy", 32'(bus.o_busy), 1);
        fillBursts("re4", 5, 10, 'h2000, 0, 1);
        chk("re4_done", 32'(bus.o_busy), 0);
`endif
        lookup('hFF, 'h05);
        chk("after_lkFF", 32'(bus.o_clutValueA), 32'h20FF);
        chk("after_lk05", 32'(bus.o_clutValueB), 32'h2005);

        // X=63: columns 504, 0, 8, ... within line 100
        load(63, 100, 1'b1);
        fillBursts("wrap", 63, 100, 'h4000, 0, 16);
        chk("wrap_done", 32'(bus.o_busy), 0);
        lookup('h00, 'hF1);
        chk("wrap_lk00", 32'(bus.o_clutValueA), 32'h4000);
        chk("wrap_lkF1", 32'(bus.o_clutValueB), 32'h40F1);

        // Reset during burst 3 of an 8-bit fill, then stray beats
        load(7, 20, 1'b1);
        fillBursts("part", 7, 20, 'h5000, 0, 3);
        waitReq("part", 7, 20, 3);
        grant();
        for (int t = 0; t < 3; t++) beat('h5000, 3, t);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", 32'(bus.o_busy), 0);
        chk("mid_req", 32'(bus.o_memReq), 0);
        for (int t = 3; t < 7; t++) beat('hD000, 3, t);
        chk("stray_req", 32'(bus.o_memReq), 0);
        chk("stray_busy", 32'(bus.o_busy), 0);
        lookup(54, 48);
        chk("stray_lk54", 32'(bus.o_clutValueA), 32'h4036);
        chk("part_lk48", 32'(bus.o_clutValueB), 32'h5030);
        lookup(61, 63);
        chk("stray_lk61", 32'(bus.o_clutValueA), 32'h403D);
        chk("stray_lk63", 32'(bus.o_clutValueB), 32'h403F);
        load(7, 20, 1'b1);
        chk("refetch_busy", 32'(bus.o_busy), 1);
        fillBursts("refetch", 7, 20, 'h6000, 0, 16);
        lookup('h37, 'hC4);
        chk("refetch_lk37", 32'(bus.o_clutValueA), 32'h6037);
        chk("refetch_lkC4", 32'(bus.o_clutValueB), 32'h60C4);

        // Lookup of entry 7 in the same cycle the fill writes it
        load(1, 2, 1'b0);
        waitReq("coll", 1, 2, 0);
        grant();
        for (int t = 0; t < 3; t++) beat('h7000, 0, t);
        bus.i_lookupValidA = 1'b1;
        bus.i_lookupValidB = 1'b1;
        bus.i_indexA       = 8'd7;
        bus.i_indexB       = 8'd7;
        beat('h7000, 0, 3);
        chk("coll_oldA", 32'(bus.o_clutValueA), 32'h6007);
        chk("coll_oldB", 32'(bus.o_clutValueB), 32'h6007);
        beat('h7000, 0, 4);
        chk("coll_newA", 32'(bus.o_clutValueA), 32'h7007);
        chk("coll_newB", 32'(bus.o_clutValueB), 32'h7007);
        bus.i_lookupValidA = 1'b0;
        bus.i_lookupValidB = 1'b0;
        for (int t = 5; t < 8; t++) beat('h7000, 0, t);
        chk("coll_done", 32'(bus.o_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
